// File: rtl/dog_filter_if.sv
// ---------------------------------------------------------------------------
// dog_filter_if
// Link between the receptive-field stage (master) and the DoG filter (slave).
//   rf           : ROWS x COLS pixel window, cell k = i*COLS + j
//   in_valid     : rf holds a valid window this cycle
//   filter_ready : filter can accept a window this cycle
//   busy         : filter is working on a window (SUM/COMP/EMIT)
//   gamma_start  : first cycle of the spike window
//   on_spike     : temporally coded spike for positive contrast
//   off_spike    : temporally coded spike for negative contrast
// ---------------------------------------------------------------------------
interface dog_filter_if #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int PIXEL_SIZE = 8
);
    logic [ROWS-1:0][COLS-1:0][PIXEL_SIZE-1:0] rf;
    logic                                      in_valid;
    logic                                      filter_ready;
    logic                                      busy;
    logic                                      gamma_start;
    logic                                      on_spike;
    logic                                      off_spike;

    modport master (
        output rf,
        output in_valid,
        input  filter_ready,
        input  busy,
        input  gamma_start,
        input  on_spike,
        input  off_spike
    );

    modport slave (
        input  rf,
        input  in_valid,
        output filter_ready,
        output busy,
        output gamma_start,
        output on_spike,
        output off_spike
    );
endinterface

// File: rtl/dog_filter.sv
// ---------------------------------------------------------------------------
// dog_filter
// Center-minus-surround (difference-of-Gaussians approximation) contrast over
// one captured ROWS x COLS window, emitted as a single temporally coded ON or
// OFF spike inside a GAMMA-cycle window. Stronger contrast spikes earlier.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : dog_filter_if.slave (rf, in_valid in; filter_ready, busy,
//            gamma_start, on_spike, off_spike out)
//
// Sequence per window: IDLE (capture) -> SUM (one cell per cycle) ->
// COMP (contrast -> spike time/polarity) -> EMIT (GAMMA cycles) -> IDLE.
// ---------------------------------------------------------------------------
module dog_filter #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int PIXEL_SIZE = 8,
    parameter int GAMMA      = 8,
    parameter int SHIFT      = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    dog_filter_if.slave bus
);

    localparam int RF_SIZE  = ROWS * COLS;
    localparam int KW       = (RF_SIZE > 1) ? $clog2(RF_SIZE) : 1;
    localparam int DW       = PIXEL_SIZE + $clog2(RF_SIZE) + 1;
    localparam int TW       = $clog2(GAMMA);
    localparam int CENTER_K = (ROWS / 2) * COLS + (COLS / 2);

    localparam logic [KW-1:0] LAST_K   = KW'(RF_SIZE - 1);
    localparam logic [KW-1:0] CENTER_I = KW'(CENTER_K);
    localparam logic [TW-1:0] LAST_T   = TW'(GAMMA - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        COMP,
        EMIT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [PIXEL_SIZE-1:0] rf_cells   [RF_SIZE];
    logic [PIXEL_SIZE-1:0] window_reg [RF_SIZE];

    logic [KW-1:0]         k_reg;
    logic [PIXEL_SIZE-1:0] center_reg;
    logic [DW-1:0]         surround_reg;
    logic [TW-1:0]         t_cnt_reg;
    logic [TW-1:0]         t_spike_reg;
    logic                  pol_on_reg;
    logic                  pol_off_reg;
    logic                  busy_reg;

    logic                  capture;
    logic                  ready_c;
    logic                  gamma_start_c;
    logic                  on_spike_c;
    logic                  off_spike_c;

    logic [DW-1:0]         center_scaled;
    logic [DW-1:0]         diff_raw;
    logic [DW-1:0]         diff_abs;
    logic [DW-1:0]         mag_full;
    logic [TW-1:0]         mag;

    // Flatten the 2-D window into cell order k = i*COLS + j and hold a
    // private copy so later changes on rf cannot disturb the computation.
    generate
        for (genvar gi = 0; gi < RF_SIZE; gi++) begin : g_cell
            assign rf_cells[gi] = bus.rf[gi / COLS][gi % COLS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    window_reg[gi] <= '0;
                end else if (capture) begin
                    window_reg[gi] <= rf_cells[gi];
                end
            end
        end
    endgenerate

    // Contrast: center weighted by the surround cell count so a uniform
    // window gives exactly zero. The product cannot exceed DW-1 bits.
    always_comb begin
        center_scaled = DW'(center_reg) * DW'(RF_SIZE - 1);
        diff_raw      = center_scaled - surround_reg;
        diff_abs      = diff_raw[DW-1] ? (~diff_raw + DW'(1)) : diff_raw;
        mag_full      = diff_abs >> SHIFT;
        mag           = (mag_full > DW'(GAMMA - 1)) ? LAST_T : mag_full[TW-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and output decodes; outputs depend only on registered state
    // so they are clean single-cycle pulses.
    always_comb begin
        state_next    = state_reg;
        capture       = 1'b0;
        ready_c       = 1'b0;
        gamma_start_c = 1'b0;
        on_spike_c    = 1'b0;
        off_spike_c   = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture    = 1'b1;
                    state_next = SUM;
                end
            end
            SUM: begin
                if (k_reg == LAST_K) begin
                    state_next = COMP;
                end
            end
            COMP: begin
                state_next = EMIT;
            end
            EMIT: begin
                gamma_start_c = (t_cnt_reg == '0);
                on_spike_c    = pol_on_reg  && (t_cnt_reg == t_spike_reg);
                off_spike_c   = pol_off_reg && (t_cnt_reg == t_spike_reg);
                if (t_cnt_reg == LAST_T) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: accumulation, contrast result and spike-time counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg        <= '0;
            center_reg   <= '0;
            surround_reg <= '0;
            t_cnt_reg    <= '0;
            t_spike_reg  <= '0;
            pol_on_reg   <= 1'b0;
            pol_off_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        k_reg        <= '0;
                        center_reg   <= '0;
                        surround_reg <= '0;
                    end
                end
                SUM: begin
                    if (k_reg == CENTER_I) begin
                        center_reg <= window_reg[k_reg];
                    end else begin
                        surround_reg <= surround_reg + DW'(window_reg[k_reg]);
                    end
                    k_reg <= k_reg + KW'(1);
                end
                COMP: begin
                    t_spike_reg <= LAST_T - mag;
                    pol_on_reg  <= !diff_raw[DW-1] && (diff_raw != '0);
                    pol_off_reg <= diff_raw[DW-1];
                    t_cnt_reg   <= '0;
                end
                EMIT: begin
                    t_cnt_reg <= t_cnt_reg + TW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // busy follows the state that will be entered, so it is already high in
    // the first SUM cycle and low in the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
        end
    end

    assign bus.filter_ready = ready_c;
    assign bus.busy         = busy_reg;
    assign bus.gamma_start  = gamma_start_c;
    assign bus.on_spike     = on_spike_c;
    assign bus.off_spike    = off_spike_c;

endmodule

// File: doc/dog_filter.md
# dog_filter

Downstream consumer of the receptive-field stage in the TNN column. It accepts one buffered ROWS×COLS pixel window and computes a center-minus-surround contrast (difference-of-Gaussians approximation). It then emits the result as temporally coded ON/OFF spikes within a GAMMA-cycle window; earlier spikes mean stronger contrast. The spikes feed the column's neuron stage, and filter_ready throttles the receptive field.

## Interface
- ROWS, 3, RF height; center row = ROWS/2
- COLS, 3, RF width; center col = COLS/2
- PIXEL_SIZE, 8, bits per pixel (unsigned)
- GAMMA, 8, spike window length in cycles (power of 2 not required, ≥2)
- SHIFT, 5, right-shift applied to contrast magnitude before time mapping
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rf  in  [ROWS-1:0][COLS-1:0][PIXEL_SIZE-1:0]  pixel window; cell index k = i*COLS+j
- in_valid  in  1  rf holds a valid window this cycle (driven by the receptive field's out_valid)
- filter_ready  out  1  block can accept a window; combinational, = (state==IDLE)
- busy  out  1  registered; high in SUM/COMP/EMIT
- gamma_start  out  1  one-cycle pulse in first EMIT cycle
- on_spike  out  1  one-cycle pulse; positive contrast
- off_spike  out  1  one-cycle pulse; negative contrast

## Operation
- RF_SIZE = ROWS*COLS. DW = PIXEL_SIZE + $clog2(RF_SIZE) + 1 (signed contrast width).
- FSM states: IDLE, SUM, COMP, EMIT.
- IDLE: if in_valid, latch rf into an internal window register, clear the accumulator and cell index, go to SUM. Otherwise stay.
- SUM: one cell per cycle, index k = 0..RF_SIZE-1. If k is the center cell, latch it as the center value; otherwise add it to surround_sum. After k = RF_SIZE-1, go to COMP.
- COMP (1 cycle):
  - diff = center*(RF_SIZE-1) − surround_sum, signed DW bits; no overflow is possible.
  - mag = |diff| >> SHIFT, clamped to GAMMA-1.
  - t_spike = GAMMA-1 − mag.
  - pol = ON if diff>0, OFF if diff<0, NONE if diff==0.
  - Load the time counter to 0, go to EMIT.
- EMIT (GAMMA cycles, counter 0..GAMMA-1):
  - gamma_start=1 at counter 0.
  - on_spike=1 iff pol==ON and counter==t_spike; off_spike likewise for OFF.
  - Exactly one spike at most per window; never both.
  - After counter==GAMMA-1, go to IDLE.
- in_valid while not IDLE: ignored; the window is not captured. The receptive field holds the window because filter_ready is low.
- rf changing after capture has no effect on the current computation.

## Timing
- Reset (async): state=IDLE, counters/accumulator/window=0. busy=0, gamma_start=0, on_spike=0, off_spike=0; filter_ready=1 (combinational from IDLE).
- Capture cycle T (IDLE & in_valid):
  - SUM occupies T+1..T+RF_SIZE.
  - COMP occupies T+RF_SIZE+1.
  - EMIT occupies T+RF_SIZE+2..T+RF_SIZE+GAMMA+1.
- gamma_start at T+RF_SIZE+2. Spike at T+RF_SIZE+2+t_spike.
- filter_ready low from T+1 through the last EMIT cycle. It is high again at T+RF_SIZE+GAMMA+2, which is the earliest next capture. With defaults, the next capture is at T+19 and the spike at T+11+t_spike.
- Spike outputs and gamma_start are registered-state decodes, glitch-free, high exactly one cycle.
- Reset asserted mid-operation: all outputs drop immediately. After release, IDLE and ready with no residual spike.

## Test plan
- Uniform window of all 100, in_valid pulse at T → gamma_start at T+11; no on_spike/off_spike during the 8 EMIT cycles; filter_ready high at T+19.
- Center 255, surround 0 → diff=2040, mag clamps 63→7, t=0: on_spike at T+11 coincident with gamma_start; off_spike never.
- Center 104, surround 100 → diff=32, mag=1, t=6: on_spike at T+17. Center 96, surround 100 → diff=−32: off_spike at T+17.
- in_valid held high continuously with alternating windows → captures at T, T+19, T+38; in_valid pulses during busy are ignored (spike pattern matches the captured windows only).
- Window changed on rf during SUM → result matches the window latched at T.
- rst_n asserted at T+14 (mid-EMIT, before a t=6 spike) → on_spike never fires; busy=0 immediately; filter_ready=1; next in_valid after release captures normally.
